// File: rtl/ir_pkg.sv
// Shared constants, receiver state type and duration-window helper for the IR link.
// Transmitter and receiver both pull their default timings from here.
package ir_pkg;

  localparam int unsigned DefSbd           = 900_000;
  localparam int unsigned DefSsd           = 450_000;
  localparam int unsigned DefBbd           = 60_000;
  localparam int unsigned DefBsd0          = 60_000;
  localparam int unsigned DefBsd1          = 160_000;
  localparam int unsigned DefMargin        = 20_000;
  localparam int unsigned DefMessageLength = 30;

  localparam int unsigned CntWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSyncBurst,
    StSyncSilence,
    StBitBurst,
    StBitSilence
  } rx_state_e;

  // True when dur-margin <= cnt <= dur+margin; one extra bit keeps the sums from wrapping.
  function automatic logic in_window(input logic [CntWidth-1:0] cnt,
                                     input int unsigned         dur,
                                     input int unsigned         margin);
    logic [CntWidth:0] c;
    logic [CntWidth:0] d;
    logic [CntWidth:0] m;
    c = {1'b0, cnt};
    d = (CntWidth + 1)'(dur);
    m = (CntWidth + 1)'(margin);
    return ((c + m) >= d) && (c <= (d + m));
  endfunction

endpackage

// File: rtl/ir_receiver_if.sv
// Line-in / message-out bundle between the IR front end, the receiver and the consumer.
interface ir_receiver_if #(
  parameter int unsigned MESSAGE_LENGTH = ir_pkg::DefMessageLength
);

  logic                      signal_in;
  logic [MESSAGE_LENGTH-1:0] data_out;
  logic                      data_valid_out;
  logic                      error_out;
  logic                      busy_out;

  modport slave (
    input  signal_in,
    output data_out,
    output data_valid_out,
    output error_out,
    output busy_out
  );

  modport master (
    output signal_in,
    input  data_out,
    input  data_valid_out,
    input  error_out,
    input  busy_out
  );

endinterface

// File: rtl/ir_level_timer.sv
// Synchronises the raw IR line, flags its edges and times how long the current level has held.
module ir_level_timer
  import ir_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_signal,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall,
  output logic [CntWidth-1:0] o_count
);

  logic                r_meta;
  logic                r_sync;
  logic                r_prev;
  logic [CntWidth-1:0] r_count;
  logic                w_rise;
  logic                w_fall;

  assign w_rise = r_sync & ~r_prev;
  assign w_fall = ~r_sync & r_prev;

  // Count restarts at 1 on each edge, so at the closing edge it equals the level length.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_meta <= i_signal;
      r_sync <= r_meta;
      r_prev <= r_sync;
      if (w_rise || w_fall) begin
        r_count <= CntWidth'(1);
      end else if (r_count != '1) begin
        r_count <= r_count + CntWidth'(1);
      end
    end
  end

  assign o_level = r_sync;
  assign o_rise  = w_rise;
  assign o_fall  = w_fall;
  assign o_count = r_count;

endmodule

// File: rtl/ir_receiver.sv
// Pulse-distance IR frame decoder: sync burst/silence, MSB-first bits, stop mark.
// Emits the word with a one-cycle valid pulse, or a one-cycle error pulse on abort.
module ir_receiver
  import ir_pkg::*;
#(
  parameter int unsigned SBD            = DefSbd,
  parameter int unsigned SSD            = DefSsd,
  parameter int unsigned BBD            = DefBbd,
  parameter int unsigned BSD0           = DefBsd0,
  parameter int unsigned BSD1           = DefBsd1,
  parameter int unsigned MARGIN         = DefMargin,
  parameter int unsigned MESSAGE_LENGTH = DefMessageLength
) (
  input logic          clk_in,
  input logic          rst_n_in,
  ir_receiver_if.slave bus
);

  localparam int unsigned BitCntW = $clog2(MESSAGE_LENGTH) + 1;

  localparam logic [CntWidth-1:0] SbdMax  = CntWidth'(SBD + MARGIN);
  localparam logic [CntWidth-1:0] SsdMax  = CntWidth'(SSD + MARGIN);
  localparam logic [CntWidth-1:0] BbdMax  = CntWidth'(BBD + MARGIN);
  localparam logic [CntWidth-1:0] Bsd1Max = CntWidth'(BSD1 + MARGIN);

  logic                w_level;
  logic                w_rise;
  logic                w_fall;
  logic [CntWidth-1:0] w_count;
  logic                w_win0;
  logic                w_win1;

  rx_state_e                 r_state;
  logic [BitCntW-1:0]        r_bit_cnt;
  logic [MESSAGE_LENGTH-1:0] r_shift;
  logic [MESSAGE_LENGTH-1:0] r_data;
  logic                      r_valid;
  logic                      r_error;
  logic                      r_busy;

  rx_state_e                 w_state_next;
  logic [BitCntW-1:0]        w_bit_cnt_next;
  logic [MESSAGE_LENGTH-1:0] w_shift_next;
  logic [MESSAGE_LENGTH-1:0] w_data_next;
  logic                      w_valid_next;
  logic                      w_busy_next;
  logic                      w_abort;

  ir_level_timer u_level_timer (
    .i_clk    (clk_in),
    .i_rst_n  (rst_n_in),
    .i_signal (bus.signal_in),
    .o_level  (w_level),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_count  (w_count)
  );

  assign w_win0 = in_window(w_count, BSD0, MARGIN);
  assign w_win1 = in_window(w_count, BSD1, MARGIN);

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_data_next    = r_data;
    w_busy_next    = r_busy;
    w_valid_next   = 1'b0;
    w_abort        = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_next   = StSyncBurst;
          w_busy_next    = 1'b1;
          w_bit_cnt_next = '0;
        end
      end
      StSyncBurst: begin
        if (w_fall) begin
          if (in_window(w_count, SBD, MARGIN)) w_state_next = StSyncSilence;
          else w_abort = 1'b1;
        end else if (w_level && (w_count > SbdMax)) begin
          w_abort = 1'b1;
        end
      end
      StSyncSilence: begin
        if (w_rise) begin
          if (in_window(w_count, SSD, MARGIN)) w_state_next = StBitBurst;
          else w_abort = 1'b1;
        end else if (!w_level && (w_count > SsdMax)) begin
          w_abort = 1'b1;
        end
      end
      StBitBurst: begin
        if (w_fall) begin
          if (in_window(w_count, BBD, MARGIN)) w_state_next = StBitSilence;
          else w_abort = 1'b1;
        end else if (w_level && (w_count > BbdMax)) begin
          w_abort = 1'b1;
        end
      end
      StBitSilence: begin
        if (w_rise) begin
          if (w_win0 || w_win1) begin
            // A zero wins if both windows ever match.
            w_shift_next   = {r_shift[MESSAGE_LENGTH-2:0], ~w_win0};
            w_bit_cnt_next = r_bit_cnt + BitCntW'(1);
            if (w_bit_cnt_next == BitCntW'(MESSAGE_LENGTH)) begin
              // This rise is the stop mark; its length is never examined.
              w_data_next    = w_shift_next;
              w_valid_next   = 1'b1;
              w_busy_next    = 1'b0;
              w_bit_cnt_next = '0;
              w_state_next   = StIdle;
            end else begin
              w_state_next = StBitBurst;
            end
          end else begin
            w_abort = 1'b1;
          end
        end else if (!w_level && (w_count > Bsd1Max)) begin
          w_abort = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (w_abort) begin
      w_state_next   = StIdle;
      w_busy_next    = 1'b0;
      w_bit_cnt_next = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_error   <= w_abort;
      r_busy    <= w_busy_next;
    end
  end

  assign bus.data_out       = r_data;
  assign bus.data_valid_out = r_valid;
  assign bus.error_out      = r_error;
  assign bus.busy_out       = r_busy;

endmodule

// File: tb/tb_ir_receiver.sv
// Directed bench for ir_receiver: per-cycle waveforms checked against a run-length frame model.
module tb_ir_receiver;

  localparam int SBD    = 90;
  localparam int SSD    = 45;
  localparam int BBD    = 6;
  localparam int BSD0   = 6;
  localparam int BSD1   = 16;
  localparam int MARGIN = 3;
  localparam int ML     = 8;
  localparam int GAP    = 30;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  ir_receiver_if #(.MESSAGE_LENGTH(ML)) rx_if ();

  ir_receiver #(
    .SBD            (SBD),
    .SSD            (SSD),
    .BBD            (BBD),
    .BSD0           (BSD0),
    .BSD1           (BSD1),
    .MARGIN         (MARGIN),
    .MESSAGE_LENGTH (ML)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (rx_if.slave)
  );

  always #5 clk_in = ~clk_in;

  int n_checks;
  int n_pass;
  int cyc;
  bit chk_en;

  bit          wave[$];
  bit          exp_valid[];
  bit          exp_err[];
  bit          exp_busy[];
  logic [ML-1:0] exp_data[];

  int          obs_valid;
  int          obs_err;
  int          first_valid_cyc;
  int          first_err_cyc;
  int          last_err_cyc;
  logic [ML-1:0] first_valid_data;
  logic [ML-1:0] last_valid_data;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, req);
  endfunction

  function automatic void add_run(input bit lvl, input int len);
    repeat (len) wave.push_back(lvl);
  endfunction

  // Transmitter: sync, nbits data bits MSB-first, one closing burst, then gap low.
  function automatic void add_frame(input logic [ML-1:0] data, input int sync_len,
                                    input int sil0, input int sil1, input int nbits,
                                    input int gap);
    add_run(1'b1, sync_len);
    add_run(1'b0, SSD);
    for (int b = 0; b < nbits; b++) begin
      add_run(1'b1, BBD);
      add_run(1'b0, data[ML-1-b] ? sil1 : sil0);
    end
    add_run(1'b1, BBD);
    add_run(1'b0, gap);
  endfunction

  function automatic bit in_win(input int l, input int d);
    return (l >= d - MARGIN) && (l <= d + MARGIN);
  endfunction

  // Raw change in cycle i is seen as an edge in cycle i+2 and on the outputs in cycle i+3.
  // A level of length L is measured as L; exceeding limit t shows as an error at start+t+4.
  function automatic void build_model();
    int            rs[$];
    int            rl[$];
    bit            rv[$];
    int            n;
    int            k;
    int            j;
    int            kind;
    int            l;
    int            t;
    int            ev;
    int            start;
    int            nb;
    bit            ok;
    bit            done;
    logic [ML-1:0] sh;
    logic [ML-1:0] cur;
    logic [ML-1:0] vd[];
    n = wave.size();
    exp_valid = new[n];
    exp_err   = new[n];
    exp_busy  = new[n];
    exp_data  = new[n];
    vd        = new[n];
    for (int i = 0; i < n; i++) begin
      if (i == 0 || wave[i] != wave[i-1]) begin
        rs.push_back(i);
        rl.push_back(1);
        rv.push_back(wave[i]);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    k = 0;
    while (k < rs.size()) begin
      if (!rv[k]) begin
        k++;
        continue;
      end
      start = rs[k];
      j     = k;
      kind  = 0;
      nb    = 0;
      sh    = '0;
      ev    = n;
      done  = 1'b0;
      while (!done) begin
        l = rl[j];
        case (kind)
          0:       begin t = SBD + MARGIN;  ok = in_win(l, SBD); end
          1:       begin t = SSD + MARGIN;  ok = in_win(l, SSD); end
          2:       begin t = BBD + MARGIN;  ok = in_win(l, BBD); end
          default: begin t = BSD1 + MARGIN; ok = in_win(l, BSD0) || in_win(l, BSD1); end
        endcase
        done = 1'b1;
        if (j == rs.size() - 1) begin
          if (l > t + 1) ev = rs[j] + t + 4;
          if (ev < n) exp_err[ev] = 1'b1;
          k = rs.size();
        end else if (!ok) begin
          if (l > t + 1) begin
            ev = rs[j] + t + 4;
            k  = j + 1;
          end else begin
            ev = rs[j] + l + 3;
            k  = j + 2;
          end
          if (ev < n) exp_err[ev] = 1'b1;
        end else if (kind == 3) begin
          sh = {sh[ML-2:0], !in_win(l, BSD0)};
          nb++;
          if (nb == ML) begin
            ev = rs[j] + l + 3;
            if (ev < n) begin
              exp_valid[ev] = 1'b1;
              vd[ev]        = sh;
            end
            k = j + 2;
          end else begin
            kind = 2;
            j++;
            done = 1'b0;
          end
        end else begin
          kind++;
          j++;
          done = 1'b0;
        end
      end
      for (int c = start + 3; c < ev && c < n; c++) exp_busy[c] = 1'b1;
    end
    cur = '0;
    for (int c = 0; c < n; c++) begin
      if (exp_valid[c]) cur = vd[c];
      exp_data[c] = cur;
    end
  endfunction

  always @(negedge clk_in) begin
    if (chk_en && cyc >= 0 && cyc < exp_valid.size()) begin
      check("valid", 32'(rx_if.data_valid_out), 32'(exp_valid[cyc]));
      check("error", 32'(rx_if.error_out), 32'(exp_err[cyc]));
      check("busy", 32'(rx_if.busy_out), 32'(exp_busy[cyc]));
      check("data", 32'(rx_if.data_out), 32'(exp_data[cyc]));
      if (rx_if.data_valid_out) begin
        if (obs_valid == 0) begin
          first_valid_cyc  = cyc;
          first_valid_data = rx_if.data_out;
        end
        obs_valid++;
        last_valid_data = rx_if.data_out;
      end
      if (rx_if.error_out) begin
        if (obs_err == 0) first_err_cyc = cyc;
        obs_err++;
        last_err_cyc = cyc;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 32'(rx_if.data_out), 32'd0);
    check({tag, "_valid"}, 32'(rx_if.data_valid_out), 32'd0);
    check({tag, "_error"}, 32'(rx_if.error_out), 32'd0);
    check({tag, "_busy"}, 32'(rx_if.busy_out), 32'd0);
  endtask

  task automatic do_reset();
    chk_en          = 1'b0;
    rx_if.signal_in = 1'b0;
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    wave.delete();
  endtask

  task automatic run_phase(input int stop_at);
    build_model();
    obs_valid       = 0;
    obs_err         = 0;
    first_valid_cyc = -1;
    first_err_cyc   = -1;
    last_err_cyc    = -1;
    for (int i = 0; i < wave.size() && (stop_at < 0 || i <= stop_at); i++) begin
      @(posedge clk_in);
      #1;
      cyc             = i;
      rx_if.signal_in = wave[i];
      chk_en          = 1'b1;
    end
  endtask

  task automatic end_phase();
    @(posedge clk_in);
    #1 chk_en = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    cyc             = -1;
    chk_en          = 1'b0;
    rx_if.signal_in = 1'b0;
    first_valid_data = '0;
    last_valid_data  = '0;

    // Loopback and back-to-back frames.
    do_reset();
    add_run(1'b0, 5);
    add_frame(8'hA5, SBD, BSD0, BSD1, ML, GAP);
    add_frame(8'h00, SBD, BSD0, BSD1, ML, GAP);
    add_frame(8'hFF, SBD, BSD0, BSD1, ML, GAP);
    run_phase(-1);
    end_phase();
    check("loop_first_valid_cyc", 32'(first_valid_cyc), 32'd279);
    check("loop_first_data", 32'(first_valid_data), 32'h0A5);
    check("loop_valid_cnt", 32'(obs_valid), 32'd3);
    check("loop_err_cnt", 32'(obs_err), 32'd0);
    check("loop_last_data", 32'(last_valid_data), 32'h0FF);

    // Tolerance edges, then a short sync and a short bit silence.
    do_reset();
    add_run(1'b0, 5);
    add_frame(8'h5A, 87, BSD0, BSD1, ML, GAP);
    add_frame(8'h96, 93, BSD0, BSD1, ML, GAP);
    add_frame(8'hE1, SBD, BSD0, 13, ML, GAP);
    add_frame(8'h1E, SBD, BSD0, 19, ML, GAP);
    add_run(1'b1, 86);
    add_run(1'b0, 60);
    add_frame(8'h7F, SBD, 11, BSD1, 1, GAP);
    run_phase(-1);
    end_phase();
    check("tol_valid_cnt", 32'(obs_valid), 32'd4);
    check("tol_err_cnt", 32'(obs_err), 32'd2);
    check("tol_short_sync_err_cyc", 32'(first_err_cyc), 32'd1322);
    check("tol_data_kept", 32'(rx_if.data_out), 32'h01E);

    // Stuck-high sync, then stuck-low after the third bit burst, then a good frame.
    do_reset();
    add_run(1'b0, 5);
    add_run(1'b1, 200);
    add_run(1'b0, 20);
    add_frame(8'hC3, SBD, BSD0, BSD1, 2, 40);
    add_frame(8'h3C, SBD, BSD0, BSD1, ML, GAP);
    run_phase(-1);
    end_phase();
    check("to_high_err_cyc", 32'(first_err_cyc), 32'd102);
    check("to_low_err_cyc", 32'(last_err_cyc), 32'd433);
    check("to_err_cnt", 32'(obs_err), 32'd2);
    check("to_valid_cnt", 32'(obs_valid), 32'd1);
    check("to_data", 32'(last_valid_data), 32'h03C);

    // Asynchronous reset in the middle of bit 4.
    do_reset();
    add_run(1'b0, 5);
    add_frame(8'hA5, SBD, BSD0, BSD1, ML, GAP);
    run_phase(215);
    #1 chk_en = 1'b0;
    check("mid_busy", 32'(rx_if.busy_out), 32'd1);
    rst_n_in        = 1'b0;
    rx_if.signal_in = 1'b0;
    #1 check_zero("mid_reset");
    repeat (3) begin
      @(negedge clk_in);
      check("mid_reset_no_err", 32'(rx_if.error_out), 32'd0);
    end
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    wave.delete();
    add_run(1'b0, 5);
    add_frame(8'h69, SBD, BSD0, BSD1, ML, GAP);
    run_phase(-1);
    end_phase();
    check("post_reset_valid_cnt", 32'(obs_valid), 32'd1);
    check("post_reset_data", 32'(last_valid_data), 32'h069);
    check("post_reset_err_cnt", 32'(obs_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
